alu_seq_ctrl: RTL and testbench

//   Multi-cycle sequencer for the ALU / register-file datapath. Accepts one pre-decoded op per issue handshake and steps it through EXEC, MEM and WB.

---
 rtl/alu_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle IDLE/EXEC/MEM/WB sequencer for the ALU/register-file datapath.
// Drives datapath controls, runs the data-memory req/ack handshake with timeout, tracks errors and retired ops.
module alu_seq_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 issue_valid_i,
  output logic                 issue_ready_o,
  input  logic [2:0]           op_class_i,
  input  logic [3:0]           alu_ctrl_i,
  input  logic                 eq_i,
  input  logic                 mem_ack_i,
  input  logic                 clr_err_i,
  output logic [3:0]           alu_ctrl_o,
  output logic                 alu_src_o,
  output logic                 reg_write_o,
  output logic                 reg_write_src_o,
  output logic                 jstore_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic                 pc_en_o,
  output logic                 branch_taken_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [CNT_WIDTH-1:0] retire_cnt_o
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  typedef enum logic [2:0] {
    OP_ALU_R   = 3'd0,
    OP_ALU_I   = 3'd1,
    OP_LOAD    = 3'd2,
    OP_STORE   = 3'd3,
    OP_BEQ     = 3'd4,
    OP_BNE     = 3'd5,
    OP_JAL     = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_t;

  state_t                 state_q, state_d;
  op_t                    op_q;
  logic [3:0]             alu_ctrl_q;
  logic [WAIT_W-1:0]      wait_q;
  logic                   err_q;
  logic [CNT_WIDTH-1:0]   retire_q;
  logic                   err_set;
  logic                   retire_inc;
  logic                   accept;

  assign accept       = (state_q == S_IDLE) && issue_valid_i;
  assign alu_ctrl_o   = alu_ctrl_q;
  assign err_o        = err_q;
  assign retire_cnt_o = retire_q;

  // Immediate-operand select held for the whole op so the ALU result stays valid for address and writeback.
  assign alu_src_o = (state_q != S_IDLE) &&
                     ((op_q == OP_ALU_I) || (op_q == OP_LOAD) || (op_q == OP_STORE));

  always_comb begin
    state_d         = state_q;
    issue_ready_o   = 1'b0;
    reg_write_o     = 1'b0;
    reg_write_src_o = 1'b0;
    jstore_o        = 1'b0;
    mem_req_o       = 1'b0;
    mem_we_o        = 1'b0;
    pc_en_o         = 1'b0;
    branch_taken_o  = 1'b0;
    done_o          = 1'b0;
    err_set         = 1'b0;
    retire_inc      = 1'b0;

    case (state_q)
      S_IDLE: begin
        issue_ready_o = 1'b1;
        if (issue_valid_i) state_d = S_EXEC;
      end

      S_EXEC: begin
        case (op_q)
          OP_ALU_R, OP_ALU_I, OP_JAL: state_d = S_WB;
          OP_LOAD, OP_STORE:          state_d = S_MEM;
          OP_BEQ, OP_BNE: begin
            pc_en_o        = 1'b1;
            branch_taken_o = (op_q == OP_BEQ) ? eq_i : ~eq_i;
            done_o         = 1'b1;
            retire_inc     = 1'b1;
            state_d        = S_IDLE;
          end
          OP_ILLEGAL: begin
            err_set = 1'b1;
            done_o  = 1'b1;
            state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end

      // An ack arriving on the last allowed cycle still completes the access.
      S_MEM: begin
        mem_req_o = 1'b1;
        mem_we_o  = (op_q == OP_STORE);
        if (mem_ack_i) begin
          if (op_q == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            pc_en_o    = 1'b1;
            done_o     = 1'b1;
            retire_inc = 1'b1;
            state_d    = S_IDLE;
          end
        end else if (wait_q == WAIT_LAST) begin
          err_set = 1'b1;
          done_o  = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_WB: begin
        reg_write_o     = 1'b1;
        reg_write_src_o = (op_q == OP_LOAD);
        jstore_o        = (op_q == OP_JAL);
        pc_en_o         = 1'b1;
        done_o          = 1'b1;
        retire_inc      = 1'b1;
        state_d         = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      op_q       <= OP_ALU_R;
      alu_ctrl_q <= 4'h0;
      wait_q     <= '0;
      err_q      <= 1'b0;
      retire_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q       <= op_t'(op_class_i);
        alu_ctrl_q <= alu_ctrl_i;
      end
      // Wait counter only runs inside MEM, so it is zero on every MEM entry.
      if (state_q != S_MEM)  wait_q <= '0;
      else if (!mem_ack_i)   wait_q <= wait_q + 1'b1;
      if (err_set)           err_q <= 1'b1;
      else if (clr_err_i)    err_q <= 1'b0;
      if (retire_inc)        retire_q <= retire_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a scoreboard of expected completions.
// A second instance with a 2-bit retire counter shares all inputs to exercise counter wrap.
module tb_alu_seq_ctrl;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       issue_valid = 1'b0;
  logic [2:0] op_class    = 3'd0;
  logic [3:0] alu_ctrl    = 4'd0;
  logic       eq          = 1'b0;
  logic       mem_ack     = 1'b0;
  logic       clr_err     = 1'b0;

  logic        issue_ready, alu_src, reg_write, reg_write_src, jstore;
  logic        mem_req, mem_we, pc_en, branch_taken, done, err;
  logic [3:0]  alu_ctrl_out;
  logic [31:0] retire_cnt;

  logic        s_issue_ready, s_alu_src, s_reg_write, s_reg_write_src, s_jstore;
  logic        s_mem_req, s_mem_we, s_pc_en, s_branch_taken, s_done, s_err;
  logic [3:0]  s_alu_ctrl_out;
  logic [1:0]  s_retire_cnt;

  alu_seq_ctrl #(.MEM_TIMEOUT(TO), .CNT_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .op_class_i(op_class), .alu_ctrl_i(alu_ctrl), .eq_i(eq), .mem_ack_i(mem_ack),
    .clr_err_i(clr_err), .alu_ctrl_o(alu_ctrl_out), .alu_src_o(alu_src),
    .reg_write_o(reg_write), .reg_write_src_o(reg_write_src), .jstore_o(jstore),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .pc_en_o(pc_en), .branch_taken_o(branch_taken),
    .done_o(done), .err_o(err), .retire_cnt_o(retire_cnt)
  );

  alu_seq_ctrl #(.MEM_TIMEOUT(TO), .CNT_WIDTH(2)) dut_w2 (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(issue_valid), .issue_ready_o(s_issue_ready),
    .op_class_i(op_class), .alu_ctrl_i(alu_ctrl), .eq_i(eq), .mem_ack_i(mem_ack),
    .clr_err_i(clr_err), .alu_ctrl_o(s_alu_ctrl_out), .alu_src_o(s_alu_src),
    .reg_write_o(s_reg_write), .reg_write_src_o(s_reg_write_src), .jstore_o(s_jstore),
    .mem_req_o(s_mem_req), .mem_we_o(s_mem_we), .pc_en_o(s_pc_en), .branch_taken_o(s_branch_taken),
    .done_o(s_done), .err_o(s_err), .retire_cnt_o(s_retire_cnt)
  );

  typedef struct {
    int   lat;
    int   memc;
    logic rw, rws, js, pc, bt, asrc, err, ret;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        model_err = 1'b0;
  logic [31:0] model_cnt = 32'd0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_ready"}, {31'd0, issue_ready}, 32'd1);
    checkOutput({tag, "_err"}, {31'd0, err}, {31'd0, model_err});
    checkOutput({tag, "_retire"}, retire_cnt, model_cnt);
    checkOutput({tag, "_retire_w2"}, {30'd0, s_retire_cnt}, model_cnt & 32'd3);
  endtask

  // ack_at: MEM cycle (1-based) in which mem_ack is driven, 0 = never
  task automatic applyStimulus(input logic [2:0] op, input logic [3:0] ctrl, input logic eq_v,
                               input int ack_at, input logic clr_during);
    exp_t e;
    exp_t got;
    int   cyc;
    int   memc;
    bit   fin;
    bit   acked;
    e = '{lat: 0, memc: 0, rw: 0, rws: 0, js: 0, pc: 0, bt: 0, asrc: 0, err: 0, ret: 0};
    acked = (ack_at >= 1) && (ack_at <= TO);
    case (op)
      3'd0, 3'd1: begin e.lat = 2; e.rw = 1; e.pc = 1; e.ret = 1; e.asrc = (op == 3'd1); end
      3'd2: begin
        e.asrc = 1;
        if (acked) begin e.lat = ack_at + 2; e.memc = ack_at; e.rw = 1; e.rws = 1; e.pc = 1; e.ret = 1; end
        else begin e.lat = TO + 1; e.memc = TO; e.err = 1; end
      end
      3'd3: begin
        e.asrc = 1;
        if (acked) begin e.lat = ack_at + 1; e.memc = ack_at; e.pc = 1; e.ret = 1; end
        else begin e.lat = TO + 1; e.memc = TO; e.err = 1; end
      end
      3'd4: begin e.lat = 1; e.pc = 1; e.bt = eq_v; e.ret = 1; end
      3'd5: begin e.lat = 1; e.pc = 1; e.bt = ~eq_v; e.ret = 1; end
      3'd6: begin e.lat = 2; e.rw = 1; e.js = 1; e.pc = 1; e.ret = 1; end
      default: begin e.lat = 1; e.err = 1; end
    endcase

    @(negedge clk);
    issue_valid = 1'b1; op_class = op; alu_ctrl = ctrl; eq = eq_v; mem_ack = 1'b0; clr_err = 1'b0;
    #1;
    checkIdle("pre_issue");
    sb.push_back(e);

    cyc = 0; memc = 0; fin = 0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      issue_valid = 1'b1;
      op_class    = 3'($urandom);
      alu_ctrl    = 4'($urandom);
      clr_err     = clr_during;
      mem_ack     = (ack_at != 0) && (cyc - 1 == ack_at);
      #1;
      checkOutput("alu_ctrl_latched", {28'd0, alu_ctrl_out}, {28'd0, ctrl});
      if (mem_req) begin
        memc++;
        checkOutput("mem_we", {31'd0, mem_we}, {31'd0, (op == 3'd3)});
      end
      if (done) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL scoreboard_empty: observed done_o with no expected entry, required entry present");
        end else begin
          got = sb.pop_front();
          checkOutput("latency", cyc, got.lat);
          checkOutput("mem_req_cycles", memc, got.memc);
          checkOutput("reg_write", {31'd0, reg_write}, {31'd0, got.rw});
          checkOutput("reg_write_src", {31'd0, reg_write_src}, {31'd0, got.rws});
          checkOutput("jstore", {31'd0, jstore}, {31'd0, got.js});
          checkOutput("pc_en", {31'd0, pc_en}, {31'd0, got.pc});
          checkOutput("branch_taken", {31'd0, branch_taken}, {31'd0, got.bt});
          checkOutput("alu_src", {31'd0, alu_src}, {31'd0, got.asrc});
          checkOutput("done_w2", {31'd0, s_done}, 32'd1);
          if (got.err) model_err = 1'b1;
          else if (clr_during) model_err = 1'b0;
          if (got.ret) model_cnt = model_cnt + 32'd1;
        end
        fin = 1;
      end else begin
        checkOutput("no_reg_write_early", {31'd0, reg_write}, 32'd0);
        checkOutput("no_pc_en_early", {31'd0, pc_en}, 32'd0);
        if (cyc > 40) begin
          checks++; errors++;
          $display("[TB] FAIL done_wait: observed no done_o in %0d cycles, required done within %0d", cyc, e.lat);
          fin = 1;
        end
      end
    end
  endtask

  initial begin
    #7;
    checkOutput("rst_ready", {31'd0, issue_ready}, 32'd1);
    checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_retire", retire_cnt, 32'd0);
    checkOutput("rst_alu_ctrl", {28'd0, alu_ctrl_out}, 32'd0);
    checkOutput("rst_reg_write", {31'd0, reg_write}, 32'd0);
    checkOutput("rst_pc_en", {31'd0, pc_en}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(3'd0, 4'h2, 1'b0, 0, 1'b0);   // ALU_R
    applyStimulus(3'd2, 4'h0, 1'b0, 3, 1'b0);   // LOAD, ack in 3rd MEM cycle
    applyStimulus(3'd4, 4'h6, 1'b1, 0, 1'b0);   // BEQ taken
    applyStimulus(3'd5, 4'h6, 1'b1, 0, 1'b0);   // BNE not taken
    applyStimulus(3'd3, 4'h0, 1'b0, 0, 1'b0);   // STORE timeout
    applyStimulus(3'd1, 4'h3, 1'b0, 0, 1'b1);   // ALU_I while clearing err
    applyStimulus(3'd7, 4'h1, 1'b0, 0, 1'b0);   // illegal
    applyStimulus(3'd6, 4'h0, 1'b0, 0, 1'b0);   // JAL with err still set
    applyStimulus(3'd3, 4'h0, 1'b0, TO, 1'b1);  // STORE, ack on timeout cycle
    applyStimulus(3'd2, 4'h9, 1'b0, 1, 1'b0);   // LOAD, immediate ack
    applyStimulus(3'd7, 4'h4, 1'b0, 0, 1'b1);   // illegal with clear: set wins
    applyStimulus(3'd4, 4'h6, 1'b0, 0, 1'b0);   // BEQ not taken
    applyStimulus(3'd5, 4'h6, 1'b0, 0, 1'b0);   // BNE taken
    applyStimulus(3'd3, 4'hA, 1'b0, 2, 1'b0);   // STORE, ack 2

    // Reset while a load sits in MEM
    @(negedge clk);
    issue_valid = 1'b1; op_class = 3'd2; alu_ctrl = 4'h5; mem_ack = 1'b0; clr_err = 1'b0;
    #1;
    checkIdle("pre_rst_issue");
    @(negedge clk);
    issue_valid = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("mid_mem_req", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_err = 1'b0;
    model_cnt = 32'd0;
    sb.delete();
    checkOutput("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("async_rst_alu_ctrl", {28'd0, alu_ctrl_out}, 32'd0);
    checkIdle("async_rst");
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(3'd0, 4'h7, 1'b0, 0, 1'b0);
    applyStimulus(3'd6, 4'h1, 1'b0, 0, 1'b0);

    @(negedge clk);
    issue_valid = 1'b0; clr_err = 1'b0; mem_ack = 1'b0;
    #1;
    checkIdle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
